rom_ram_copy_ctrl: RTL
======================

ROM_RAM_COPY_CTRL -- requirements
Module: rom_ram_copy_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, ROM/RAM address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width.
REQ-003 SHALL have parameter DEPTH, default 256, words copied per run; legal range 1..2**ADDR_WIDTH.
REQ-004 SHALL have port clk, input, 1, single clock, all state on rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port start, input, 1, request a copy run; sampled only in IDLE or DONE.
REQ-007 SHALL have port rom_addr, output, ADDR_WIDTH, synchronous ROM read address.
REQ-008 SHALL have port rom_data, input, DATA_WIDTH, ROM word; valid one cycle after rom_addr is presented.
REQ-009 SHALL have port ram_we, output, 1, RAM write enable.
REQ-010 SHALL have port ram_addr, output, ADDR_WIDTH, RAM write address.
REQ-011 SHALL have port ram_wdata, output, DATA_WIDTH, RAM write data; equals rom_data combinationally.
REQ-012 SHALL have port busy, output, 1, high in READ and DRAIN.
REQ-013 SHALL have port complete, output, 1, high in DONE.
REQ-014 SHALL have port checksum, output, DATA_WIDTH, XOR of all words written this run.

Function
REQ-015 SHALL implement states IDLE, READ, DRAIN, DONE.
REQ-016 IDLE: start=1 SHALL go to READ with rom_addr=0 and checksum cleared to 0 on the same edge.
REQ-017 READ: rom_addr SHALL increment by 1 per cycle; when rom_addr==DEPTH-1 the next state SHALL be DRAIN and rom_addr SHALL hold.
REQ-018 SHALL delay rom_addr by one register stage (p_addr) plus a valid flag (p_valid) set for every READ cycle.
REQ-019 ram_we SHALL equal p_valid; ram_addr SHALL equal p_addr; the write of word k SHALL occur the cycle after rom_addr=k.
REQ-020 DRAIN: SHALL last exactly one cycle, perform the final write (address DEPTH-1), then go to DONE.
REQ-021 checksum SHALL update as checksum XOR rom_data on every cycle with ram_we=1; it SHALL hold in DONE and IDLE.
REQ-022 Run latency: start sampled at edge 0 -> first write in cycle 2, last write in cycle DEPTH+1, complete high from cycle DEPTH+2.
REQ-023 DONE: complete SHALL stay high until start=1, which SHALL begin a new run exactly as from IDLE.
REQ-024 start during READ or DRAIN SHALL be ignored with no effect on address, write stream or checksum.
REQ-025 DEPTH=1: SHALL perform one READ cycle at address 0, one DRAIN write, then DONE.
REQ-026 DEPTH=2**ADDR_WIDTH: rom_addr SHALL never wrap; last address is all-ones.
REQ-027 Exactly DEPTH writes per run, addresses 0..DEPTH-1 ascending, no duplicates or gaps.

Reset
REQ-028 reset=1 SHALL, on the next edge, force IDLE, rom_addr=0, p_addr=0, p_valid=0, checksum=0; reset overrides start.
REQ-029 Reset mid-run SHALL deassert ram_we from the edge on which reset is sampled; no further writes occur.
REQ-030 After reset, busy=0, complete=0, ram_we=0.

Structure
REQ-031 State encoding (2-bit, IDLE=0, READ=1, DRAIN=2, DONE=3) SHALL reside in shared package vga_pkg.
REQ-032 The address counter SHALL be a sub-module copy_addr_counter (load-zero, enable, terminal-count output).

Verification (DEPTH=4, ROM = 0x00000011, 0x00000022, 0x00000044, 0x00000088)
REQ-033 Reset then 1-cycle start pulse -> writes (0,0x11),(1,0x22),(2,0x44),(3,0x88) in cycles 2..5; complete=1 from cycle 6; checksum=0x000000FF.
REQ-034 start held high through a whole run -> single run only, exactly 4 writes, then immediate restart from DONE with checksum cleared.
REQ-035 reset asserted in cycle 3 of a run -> ram_we=0 from cycle 4, state IDLE, complete=0, checksum=0.
REQ-036 DEPTH=1, ROM[0]=0xDEADBEEF -> one write (0,0xDEADBEEF) in cycle 2, complete in cycle 3, checksum=0xDEADBEEF.
REQ-037 ADDR_WIDTH=2, DEPTH=4 -> rom_addr reaches 3 and holds; no write to address 0 after the first.
REQ-038 start and reset both high in IDLE -> remains IDLE, busy=0, no write.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared state encoding for the ROM-to-RAM copy controller.
`timescale 1ns/1ps
package vga_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } copy_state_e;

endpackage

// File: rtl/rom_ram_copy_ctrl_addr_counter.sv
// ROM read address counter: synchronous clear, count enable, saturates at DEPTH-1.
`timescale 1ns/1ps
module copy_addr_counter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256
) (
  input  logic                  clk,
  input  logic                  clr_i,
  input  logic                  en_i,
  output logic [ADDR_WIDTH-1:0] count_o,
  output logic                  tc_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

  logic [ADDR_WIDTH-1:0] count_q, count_d;

  // Holding at the terminal count keeps DEPTH == 2**ADDR_WIDTH from wrapping.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && !tc_o) begin
      count_d = count_q + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign count_o = count_q;
  assign tc_o    = (count_q == LAST);

endmodule

// File: rtl/rom_ram_copy_ctrl.sv
// Copies DEPTH words from a synchronous ROM into a RAM, XOR-accumulating a checksum.
`timescale 1ns/1ps
module rom_ram_copy_ctrl
  import vga_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  busy,
  output logic                  complete,
  output logic [DATA_WIDTH-1:0] checksum,
  output copy_state_e           dbg_state
);

  copy_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] p_addr_q, p_addr_d;
  logic                  p_valid_q, p_valid_d;
  logic [DATA_WIDTH-1:0] checksum_q, checksum_d;
  logic                  launch;
  logic                  tc;

  copy_addr_counter #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_addr_cnt (
    .clk     (clk),
    .clr_i   (reset | launch),
    .en_i    (state_q == ST_READ),
    .count_o (rom_addr),
    .tc_o    (tc)
  );

  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_READ;
          launch  = 1'b1;
        end
      end
      ST_READ:  if (tc) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // One-stage pipeline aligns the write address with the ROM's read latency.
  always_comb begin
    p_valid_d  = (state_q == ST_READ);
    p_addr_d   = rom_addr;
    checksum_d = checksum_q;
    if (launch) begin
      checksum_d = '0;
    end else if (p_valid_q) begin
      checksum_d = checksum_q ^ rom_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      p_addr_q   <= '0;
      p_valid_q  <= 1'b0;
      checksum_q <= '0;
    end else begin
      state_q    <= state_d;
      p_addr_q   <= p_addr_d;
      p_valid_q  <= p_valid_d;
      checksum_q <= checksum_d;
    end
  end

  assign ram_we    = p_valid_q;
  assign ram_addr  = p_addr_q;
  assign ram_wdata = rom_data;
  assign busy      = (state_q == ST_READ) || (state_q == ST_DRAIN);
  assign complete  = (state_q == ST_DONE);
  assign checksum  = checksum_q;
  assign dbg_state = state_q;

endmodule
